// File: rtl/binary_down_counter_reload.sv
// Cascadable down counter with parallel load, borrow-out and optional auto-reload.
// Serves as a programmable interval timer with a saturating expiry-event count.
module binary_down_counter_reload #(
    parameter int unsigned W     = 4,
    parameter int unsigned EXP_W = 8
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic [W-1:0]     data_in,
    input  logic             load,
    input  logic             count,
    input  logic             auto_reload,
    output logic [W-1:0]     A_count,
    output logic             b_out,
    output logic             done,
    output logic             busy,
    output logic [EXP_W-1:0] exp_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_count;
    logic [W-1:0]     r_reload;
    logic             r_done;
    logic             r_busy;
    logic [EXP_W-1:0] r_exp;
    logic             w_expire;

    // Expiry replaces the wrap to all-ones; load always wins over count.
    assign w_expire = (r_state == RUN) && count && !load && (r_count == '0);

    always_ff @(posedge clk) begin
        if (!clear_b) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_exp    <= '0;
        end else begin
            r_done <= w_expire;
            if (w_expire && (r_exp != '1)) begin
                r_exp <= r_exp + 1'b1;
            end
            if (load) begin
                r_count  <= data_in;
                r_reload <= data_in;
                r_state  <= RUN;
                r_busy   <= 1'b1;
            end else if ((r_state == RUN) && count) begin
                if (r_count == '0) begin
                    if (auto_reload) begin
                        r_count <= r_reload;
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign A_count = r_count;
    assign b_out   = w_expire;
    assign done    = r_done;
    assign busy    = r_busy;
    assign exp_cnt = r_exp;

endmodule

// File: tb/tb_binary_down_counter_reload.sv
// Bench for binary_down_counter_reload: vector table with an expected-output queue,
// plus a hand-written auto-reload-from-zero sequence checking exp_cnt saturation.
module tb_binary_down_counter_reload;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear_b, load, count, auto_reload;
    logic [W-1:0]  data_in;
    logic [W-1:0]  A_count, A_count2;
    logic          b_out, b_out2, done, done2, busy, busy2;
    logic [7:0]    exp_cnt;
    logic [1:0]    exp_cnt2;

    binary_down_counter_reload #(.W(W), .EXP_W(8)) dut (
        .clk(clk), .clear_b(clear_b), .data_in(data_in), .load(load),
        .count(count), .auto_reload(auto_reload), .A_count(A_count),
        .b_out(b_out), .done(done), .busy(busy), .exp_cnt(exp_cnt)
    );

    binary_down_counter_reload #(.W(W), .EXP_W(2)) dut2 (
        .clk(clk), .clear_b(clear_b), .data_in(data_in), .load(load),
        .count(count), .auto_reload(auto_reload), .A_count(A_count2),
        .b_out(b_out2), .done(done2), .busy(busy2), .exp_cnt(exp_cnt2)
    );

    typedef struct {
        logic         clr_b, ld, cnt, ar;
        logic [W-1:0] din;
        logic         b;
        logic [W-1:0] a;
        logic         d, bz;
        logic [7:0]   e;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic         d, bz;
        logic [7:0]   e;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic vec_t mk(logic c, logic l, logic n, logic r, logic [W-1:0] di,
                                logic b, logic [W-1:0] a, logic d, logic bz, logic [7:0] e);
        vec_t v;
        v.clr_b = c; v.ld = l; v.cnt = n; v.ar = r; v.din = di;
        v.b = b; v.a = a; v.d = d; v.bz = bz; v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    endtask

    task automatic drive(input logic c, input logic l, input logic n, input logic r, input logic [W-1:0] di);
        clear_b = c; load = l; count = n; auto_reload = r; data_in = di;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t x, got;
        @(negedge clk);
        drive(v.clr_b, v.ld, v.cnt, v.ar, v.din);
        #1 chk("b_out", idx, b_out, v.b);
        x.a = v.a; x.d = v.d; x.bz = v.bz; x.e = v.e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("A_count", idx, A_count, got.a);
        chk("done",    idx, done,    got.d);
        chk("busy",    idx, busy,    got.bz);
        chk("exp_cnt", idx, exp_cnt, got.e);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        //              clr ld cnt ar din   b  A  d  bz e
        vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(1, 1, 0, 0, 3,    0, 3, 0, 1, 0)); // load 3, stop mode
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,    1, 0, 1, 0, 1)); // expiry -> DONE
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 0, 0, 0, 1)); // DONE ignores count
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 2,    0, 2, 0, 1, 1)); // load 2, auto-reload
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 1, 0,    1, 2, 1, 1, 2));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 1, 0, 1, 2));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 1, 1, 0,    1, 2, 1, 1, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 1, 0, 1, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 1, 1, 0,    1, 2, 1, 1, 4));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 1, 0, 1, 4));
        vecs.push_back(mk(1, 0, 1, 1, 0,    0, 0, 0, 1, 4));
        vecs.push_back(mk(1, 1, 1, 1, 5,    0, 5, 0, 1, 4)); // load beats expiry at 0
        vecs.push_back(mk(1, 0, 0, 0, 0,    0, 5, 0, 1, 4)); // pause
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 4, 0, 1, 4));
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 3, 0, 1, 4));
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 2, 0, 1, 4));
        vecs.push_back(mk(0, 1, 1, 0, 7,    0, 0, 0, 0, 0)); // reset beats load mid-run
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 0, 0, 0, 0)); // IDLE ignores count
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,    0, 0, 0, 1, 0)); // load 0
        vecs.push_back(mk(1, 0, 1, 0, 0,    1, 0, 1, 0, 1)); // immediate expiry
        vecs.push_back(mk(1, 0, 1, 0, 0,    0, 0, 0, 0, 1));

        foreach (vecs[i]) apply(vecs[i], i);

        // Reload value 0 with auto-reload: expiry every count cycle, EXP_W=2 saturates.
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b1, 1'b1, '0);
            #1;
            chk("sat_b_out", i, b_out, 1'b1);
            chk("sat_b_out2", i, b_out2, 1'b1);
            @(posedge clk);
            #1;
            chk("sat_exp_cnt2", i, exp_cnt2, (i < 2) ? i + 1 : 3);
            chk("sat_exp_cnt", i, exp_cnt, i + 1);
            chk("sat_done2", i, done2, 1'b1);
            chk("sat_A_count", i, A_count, 0);
            chk("sat_busy", i, busy, 1'b1);
        end
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        chk("sat_done_end", 0, done2, 1'b0);
        chk("sat_busy_end", 0, busy2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/binary_down_counter_reload.md
Name: binary_down_counter_reload

Overview:
- Parameterised, cascadable down counter with parallel load and borrow-out; the count-down counterpart of the team's 4-bit up counter with parallel load and carry-out.
- Used as a programmable interval timer: it loads a start value, decrements on `count`, signals expiry on borrow, and either stops or auto-reloads.
- `b_out` chains into the `count` input of the next more-significant stage, the same way the up counter's carry-out chains.

Parameters:
- `W`, 4, counter width in bits (min 2).
- `EXP_W`, 8, width of the saturating expiry-event counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `clear_b`  in  1  reset: synchronous, active-low; highest priority.
- `data_in`  in  W  parallel load value.
- `load`  in  1  parallel load strobe; priority over `count`.
- `count`  in  1  decrement enable.
- `auto_reload`  in  1  1 = reload on expiry and keep running; 0 = stop at expiry.
- `A_count`  out  W  current count, registered.
- `b_out`  out  1  borrow, combinational: `(A_count == 0) & count & !load & (state == RUN)`.
- `done`  out  1  registered, one-cycle pulse the cycle after each expiry.
- `busy`  out  1  registered, high while `state == RUN`.
- `exp_cnt`  out  EXP_W  saturating count of expiries since reset.

Behaviour:
- Reset (`clear_b == 0` at a clock edge):
  - State goes to IDLE.
  - `A_count`, the reload register R, `done`, `busy` and `exp_cnt` all go to 0.
  - Reset mid-RUN aborts with no `done` pulse.
  - `b_out` is 0 because the state is IDLE.
- States: IDLE, RUN, DONE, encoded in 2 bits.
- `load` in any state (with `clear_b == 1`):
  - `A_count <= data_in`, `R <= data_in`, state goes to RUN.
  - `count` is ignored that cycle; `b_out == 0`.
- IDLE and DONE: `A_count` holds its value; `count` is ignored; `b_out == 0`; `busy == 0`.
- RUN, `count == 1`, `A_count != 0`: `A_count <= A_count - 1`.
- RUN, `count == 1`, `A_count == 0` (expiry):
  - `b_out == 1` combinationally that cycle.
  - `done == 1` on the next cycle.
  - `exp_cnt` increments and saturates at all-ones.
  - If `auto_reload == 1`: `A_count <= R` and the state stays RUN.
  - If `auto_reload == 0`: `A_count` stays 0 and the state goes to DONE.
- RUN, `count == 0`: hold (pause); `b_out == 0`.
- Load value 0: the first `count` in RUN expires immediately.
- R == 0 with `auto_reload == 1`: expires on every `count` cycle; `A_count` stays 0.
- `auto_reload` is sampled only in the expiry cycle; changing it mid-count has no other effect.
- `done` is a single-cycle pulse. Back-to-back expiries produce `done` high on consecutive cycles, one per expiry.
- Arithmetic is modulo 2^W. `A_count` never wraps to all-ones; expiry replaces the wrap.
- `busy` is registered and equals `(next_state == RUN)`, so it rises on the cycle after `load`.

Test Plan:
- Reset then `load=1, data_in=4'd3`; then `count=1` for 4 cycles → `A_count` goes 3,2,1,0; `b_out=1` in the 4th cycle; `done=1` in the 5th; state DONE; `exp_cnt=1`; further `count` has no effect.
- `auto_reload=1`, load 2, `count` held high for 9 cycles → `A_count` sequence 2,1,0,2,1,0,2,1,0; `b_out` high on each 0 cycle; 3 `done` pulses; `exp_cnt=3`; `busy` stays 1.
- In RUN with `A_count=0`, assert `load=1, data_in=4'd5` together with `count=1` → no `b_out`, no `done`; `A_count=5` next cycle.
- Mid-RUN at `A_count=2`, drop `clear_b` for 1 cycle with `load=1` → all outputs 0, state IDLE, no `done`. After release, `count` pulses leave `A_count=0` and `b_out=0`.
- Load 0 with `auto_reload=0`, then `count=1` → `b_out=1` in the first count cycle; `done` the next cycle; state DONE.
- `EXP_W=2`, `auto_reload=1`, load 0, `count=1` for 6 cycles → `exp_cnt` goes 1,2,3,3,3,3 (saturates); `done` high on each of the 6 cycles following each expiry.
